kamus_l1d_arbiter: RTL and testbench

Shares the single L1 data cache port between two requesters: the core MEM stage (port 0, "core") and a secondary master (port 1, "aux", e.g. debug/loader DMA). Accepts requests on a valid/ready handshake, issues one transaction at a time to the cache over a req/gnt + rvalid protocol, and returns read data or a write acknowledgement to the owning port. Core has priority, with a starvation counter that guarantees aux progress. The block sits between kamus_MEM and the L1D.

---
 rtl/kamus_l1d_arbiter.sv | 156 +++++++++++++++
 tb/tb_kamus_l1d_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kamus_l1d_arbiter.sv
// Two-port arbiter in front of the L1 data cache: core has priority, aux is
// guaranteed progress by a starvation counter. One cache transaction in flight.
module kamus_l1d_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_CORE_WINS = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                core_valid_i,
    output logic                core_ready_o,
    input  logic                core_we_i,
    input  logic [ADDR_W-1:0]   core_addr_i,
    input  logic [DATA_W-1:0]   core_wdata_i,
    input  logic [DATA_W/8-1:0] core_be_i,
    output logic                core_rsp_valid_o,
    output logic [DATA_W-1:0]   core_rsp_rdata_o,

    input  logic                aux_valid_i,
    output logic                aux_ready_o,
    input  logic                aux_we_i,
    input  logic [ADDR_W-1:0]   aux_addr_i,
    input  logic [DATA_W-1:0]   aux_wdata_i,
    input  logic [DATA_W/8-1:0] aux_be_i,
    output logic                aux_rsp_valid_o,
    output logic [DATA_W-1:0]   aux_rsp_rdata_o,

    output logic                l1d_req_o,
    input  logic                l1d_gnt_i,
    output logic                l1d_we_o,
    output logic [ADDR_W-1:0]   l1d_addr_o,
    output logic [DATA_W-1:0]   l1d_wdata_o,
    output logic [DATA_W/8-1:0] l1d_be_o,
    input  logic                l1d_rvalid_i,
    input  logic [DATA_W-1:0]   l1d_rdata_i,

    output logic                busy_o
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_CORE_WINS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_reg;
    logic                owner_reg;          // 0 = core, 1 = aux
    logic [CNT_W-1:0]    starve_cnt_reg;
    logic                we_reg;
    logic [ADDR_W-3:0]   addr_reg;           // word address; byte offset is dropped
    logic [DATA_W-1:0]   wdata_reg;
    logic [BE_W-1:0]     be_reg;
    logic                req_reg;
    logic                busy_reg;
    logic                core_rsp_valid_reg;
    logic                aux_rsp_valid_reg;
    logic [DATA_W-1:0]   core_rsp_rdata_reg;
    logic [DATA_W-1:0]   aux_rsp_rdata_reg;

    logic starved;
    logic any_valid;
    logic aux_wins;
    logic accept;
    logic unused_addr_lsb;

    assign starved   = (starve_cnt_reg == CNT_W'(MAX_CORE_WINS));
    assign any_valid = core_valid_i || aux_valid_i;
    assign aux_wins  = aux_valid_i && (!core_valid_i || starved);
    assign accept    = (state_reg == IDLE) && any_valid && !rst_i;

    assign core_ready_o = accept && !aux_wins;
    assign aux_ready_o  = accept && aux_wins;

    // The cache is word-addressed, so the byte offset never reaches it.
    assign unused_addr_lsb = ^{core_addr_i[1:0], aux_addr_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg          <= IDLE;
            owner_reg          <= 1'b0;
            starve_cnt_reg     <= '0;
            we_reg             <= 1'b0;
            addr_reg           <= '0;
            wdata_reg          <= '0;
            be_reg             <= '0;
            req_reg            <= 1'b0;
            busy_reg           <= 1'b0;
            core_rsp_valid_reg <= 1'b0;
            aux_rsp_valid_reg  <= 1'b0;
            core_rsp_rdata_reg <= '0;
            aux_rsp_rdata_reg  <= '0;
        end else begin
            core_rsp_valid_reg <= 1'b0;
            aux_rsp_valid_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_valid) begin
                        owner_reg <= aux_wins;
                        we_reg    <= aux_wins ? aux_we_i    : core_we_i;
                        addr_reg  <= aux_wins ? aux_addr_i[ADDR_W-1:2] : core_addr_i[ADDR_W-1:2];
                        wdata_reg <= aux_wins ? aux_wdata_i : core_wdata_i;
                        be_reg    <= aux_wins ? aux_be_i    : core_be_i;
                        req_reg   <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= REQ;
                        // Count core wins only while aux is actually waiting.
                        if (aux_wins) begin
                            starve_cnt_reg <= '0;
                        end else if (aux_valid_i && !starved) begin
                            starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                REQ: begin
                    if (l1d_gnt_i) begin
                        req_reg   <= 1'b0;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (l1d_rvalid_i) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        if (owner_reg) begin
                            aux_rsp_valid_reg <= 1'b1;
                            aux_rsp_rdata_reg <= we_reg ? '0 : l1d_rdata_i;
                        end else begin
                            core_rsp_valid_reg <= 1'b1;
                            core_rsp_rdata_reg <= we_reg ? '0 : l1d_rdata_i;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign l1d_req_o        = req_reg;
    assign l1d_we_o         = we_reg;
    assign l1d_addr_o       = {addr_reg, 2'b00};
    assign l1d_wdata_o      = wdata_reg;
    assign l1d_be_o         = be_reg;
    assign busy_o           = busy_reg;
    assign core_rsp_valid_o = core_rsp_valid_reg;
    assign core_rsp_rdata_o = core_rsp_rdata_reg;
    assign aux_rsp_valid_o  = aux_rsp_valid_reg;
    assign aux_rsp_rdata_o  = aux_rsp_rdata_reg;

endmodule

// File: tb/tb_kamus_l1d_arbiter.sv
// Bench for kamus_l1d_arbiter: directed scenarios plus a randomized run against
// a transaction-level model of the arbitration and response routing rules.
module tb_kamus_l1d_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int MAXW   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              core_valid, core_ready, core_we, core_rsp_valid;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata, core_rsp_rdata;
    logic [BE_W-1:0]   core_be;
    logic              aux_valid, aux_ready, aux_we, aux_rsp_valid;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata, aux_rsp_rdata;
    logic [BE_W-1:0]   aux_be;
    logic              l1d_req, l1d_gnt, l1d_we, l1d_rvalid, busy;
    logic [ADDR_W-1:0] l1d_addr;
    logic [DATA_W-1:0] l1d_wdata, l1d_rdata;
    logic [BE_W-1:0]   l1d_be;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    kamus_l1d_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CORE_WINS(MAXW)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_valid_i(core_valid), .core_ready_o(core_ready), .core_we_i(core_we),
        .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_be_i(core_be),
        .core_rsp_valid_o(core_rsp_valid), .core_rsp_rdata_o(core_rsp_rdata),
        .aux_valid_i(aux_valid), .aux_ready_o(aux_ready), .aux_we_i(aux_we),
        .aux_addr_i(aux_addr), .aux_wdata_i(aux_wdata), .aux_be_i(aux_be),
        .aux_rsp_valid_o(aux_rsp_valid), .aux_rsp_rdata_o(aux_rsp_rdata),
        .l1d_req_o(l1d_req), .l1d_gnt_i(l1d_gnt), .l1d_we_o(l1d_we),
        .l1d_addr_o(l1d_addr), .l1d_wdata_o(l1d_wdata), .l1d_be_o(l1d_be),
        .l1d_rvalid_i(l1d_rvalid), .l1d_rdata_i(l1d_rdata),
        .busy_o(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_valid = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_be = '0;
        aux_valid  = 0; aux_we  = 0; aux_addr  = '0; aux_wdata  = '0; aux_be  = '0;
        l1d_gnt = 0; l1d_rvalid = 0; l1d_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        chk_cnt++; if ({core_ready, aux_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {core_ready, aux_ready}); else pass_cnt++;
        chk_cnt++; if ({core_rsp_valid, aux_rsp_valid} !== 2'b00) $display("FAIL reset_rsp_valid: got %b want 00", {core_rsp_valid, aux_rsp_valid}); else pass_cnt++;
        chk_cnt++; if ({core_rsp_rdata, aux_rsp_rdata} !== 64'h0) $display("FAIL reset_rsp_rdata: got %h want 0", {core_rsp_rdata, aux_rsp_rdata}); else pass_cnt++;
        chk_cnt++; if ({l1d_req, l1d_we, l1d_addr, l1d_wdata, l1d_be} !== '0) $display("FAIL reset_l1d: got req=%b we=%b addr=%h wdata=%h be=%h want all 0", l1d_req, l1d_we, l1d_addr, l1d_wdata, l1d_be); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        rst = 0;
        $display("txn reset done");
    endtask

    task automatic test_single_read();
        core_valid = 1; core_we = 0; core_addr = 32'h0000_0106; core_be = 4'hF;
        #1;
        chk_cnt++; if ({core_ready, aux_ready} !== 2'b10) $display("FAIL rd_ready: got %b want 10", {core_ready, aux_ready}); else pass_cnt++;
        tick();
        core_valid = 0;
        chk_cnt++; if ({l1d_req, l1d_we, l1d_addr} !== {1'b1, 1'b0, 32'h0000_0104}) $display("FAIL rd_req: got req=%b we=%b addr=%h want 1 0 00000104", l1d_req, l1d_we, l1d_addr); else pass_cnt++;
        l1d_gnt = 1;
        tick();
        l1d_gnt = 0; l1d_rvalid = 1; l1d_rdata = 32'hDEADBEEF;
        chk_cnt++; if ({l1d_req, busy} !== 2'b01) $display("FAIL rd_resp_phase: got req=%b busy=%b want 0 1", l1d_req, busy); else pass_cnt++;
        tick();
        l1d_rvalid = 0;
        chk_cnt++; if ({core_rsp_valid, aux_rsp_valid} !== 2'b10) $display("FAIL rd_rsp_valid: got %b want 10", {core_rsp_valid, aux_rsp_valid}); else pass_cnt++;
        chk_cnt++; if (core_rsp_rdata !== 32'hDEADBEEF) $display("FAIL rd_rsp_rdata: got %h want deadbeef", core_rsp_rdata); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rd_busy_after: got %b want 0", busy); else pass_cnt++;
        tick();
        chk_cnt++; if (core_rsp_valid !== 1'b0 || core_rsp_rdata !== 32'hDEADBEEF) $display("FAIL rd_rsp_pulse_hold: got v=%b d=%h want 0 deadbeef", core_rsp_valid, core_rsp_rdata); else pass_cnt++;
        $display("txn core read addr=00000106 rdata=%h", core_rsp_rdata);
    endtask

    task automatic test_aux_write_stall();
        aux_valid = 1; aux_we = 1; aux_addr = 32'h40; aux_wdata = 32'h12345678; aux_be = 4'b0011;
        #1;
        chk_cnt++; if ({core_ready, aux_ready} !== 2'b01) $display("FAIL wr_ready: got %b want 01", {core_ready, aux_ready}); else pass_cnt++;
        tick();
        aux_valid = 0;
        for (int i = 0; i < 4; i++) begin
            l1d_gnt = (i == 3);
            chk_cnt++; if ({l1d_req, l1d_we, l1d_addr, l1d_wdata, l1d_be} !== {1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011})
                $display("FAIL wr_stall_fields cyc%0d: got req=%b we=%b addr=%h wdata=%h be=%b want 1 1 00000040 12345678 0011", i, l1d_req, l1d_we, l1d_addr, l1d_wdata, l1d_be); else pass_cnt++;
            tick();
        end
        l1d_gnt = 0; l1d_rvalid = 1; l1d_rdata = 32'hCAFEF00D;
        chk_cnt++; if (l1d_req !== 1'b0) $display("FAIL wr_req_drop: got %b want 0", l1d_req); else pass_cnt++;
        tick();
        l1d_rvalid = 0;
        chk_cnt++; if ({core_rsp_valid, aux_rsp_valid} !== 2'b01) $display("FAIL wr_rsp_valid: got %b want 01", {core_rsp_valid, aux_rsp_valid}); else pass_cnt++;
        chk_cnt++; if (aux_rsp_rdata !== 32'h0) $display("FAIL wr_rsp_rdata: got %h want 0", aux_rsp_rdata); else pass_cnt++;
        $display("txn aux write addr=00000040 wdata=12345678 be=0011");
    endtask

    task automatic test_starvation();
        logic exp_aux;
        rst = 1; idle_inputs(); tick(); rst = 0;
        core_valid = 1; core_we = 0; core_addr = 32'h100; core_be = 4'hF;
        aux_valid  = 1; aux_we  = 0; aux_addr  = 32'h200; aux_be  = 4'hF;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_aux = ((i % (MAXW + 1)) == MAXW);
            chk_cnt++; if ({core_ready, aux_ready} !== (exp_aux ? 2'b01 : 2'b10)) $display("FAIL starve_grant%0d: got %b want %b", i, {core_ready, aux_ready}, exp_aux ? 2'b01 : 2'b10); else pass_cnt++;
            tick();
            l1d_gnt = 1;
            chk_cnt++; if (l1d_addr !== (exp_aux ? 32'h200 : 32'h100)) $display("FAIL starve_addr%0d: got %h want %h", i, l1d_addr, exp_aux ? 32'h200 : 32'h100); else pass_cnt++;
            tick();
            l1d_gnt = 0; l1d_rvalid = 1; l1d_rdata = 32'(i);
            tick();
            l1d_rvalid = 0;
            chk_cnt++; if ({core_rsp_valid, aux_rsp_valid} !== (exp_aux ? 2'b01 : 2'b10)) $display("FAIL starve_rsp%0d: got %b want %b", i, {core_rsp_valid, aux_rsp_valid}, exp_aux ? 2'b01 : 2'b10); else pass_cnt++;
            $display("txn starvation grant %0d -> %s", i, exp_aux ? "aux" : "core");
        end
        core_valid = 0; aux_valid = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        core_valid = 1; core_we = 0; core_be = 4'hF; core_addr = 32'h1000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_cnt++; if (core_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", i, core_ready); else pass_cnt++;
            if (i > 0) begin
                chk_cnt++; if ({core_rsp_valid, core_rsp_rdata} !== {1'b1, 32'hA0 + 32'(i - 1)}) $display("FAIL b2b_rsp%0d: got v=%b d=%h want 1 %h", i - 1, core_rsp_valid, core_rsp_rdata, 32'hA0 + 32'(i - 1)); else pass_cnt++;
            end
            tick();
            if (i < 2) core_addr = 32'h1000 + 32'(4 * (i + 1));
            else core_valid = 0;
            chk_cnt++; if ({l1d_req, l1d_addr} !== {1'b1, 32'h1000 + 32'(4 * i)}) $display("FAIL b2b_req%0d: got req=%b addr=%h want 1 %h", i, l1d_req, l1d_addr, 32'h1000 + 32'(4 * i)); else pass_cnt++;
            l1d_gnt = 1;
            tick();
            l1d_gnt = 0; l1d_rvalid = 1; l1d_rdata = 32'hA0 + 32'(i);
            tick();
            l1d_rvalid = 0;
            $display("txn back-to-back %0d addr=%h", i, 32'h1000 + 32'(4 * i));
        end
        chk_cnt++; if ({core_rsp_valid, core_rsp_rdata, core_ready} !== {1'b1, 32'hA2, 1'b0}) $display("FAIL b2b_last: got v=%b d=%h rdy=%b want 1 a2 0", core_rsp_valid, core_rsp_rdata, core_ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        core_valid = 1; core_we = 0; core_addr = 32'h300; core_be = 4'hF;
        tick();
        core_valid = 0; l1d_gnt = 1;
        tick();
        l1d_gnt = 0;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy); else pass_cnt++;
        rst = 1;
        tick();
        rst = 0; l1d_rvalid = 1; l1d_rdata = 32'h55;
        chk_cnt++; if ({busy, l1d_req, core_rsp_valid, core_rsp_rdata, l1d_addr} !== '0) $display("FAIL rstmid_outputs: got busy=%b req=%b v=%b d=%h addr=%h want all 0", busy, l1d_req, core_rsp_valid, core_rsp_rdata, l1d_addr); else pass_cnt++;
        tick();
        l1d_rvalid = 0;
        chk_cnt++; if ({core_rsp_valid, aux_rsp_valid, busy} !== 3'b000) $display("FAIL rstmid_late_rvalid: got %b want 000", {core_rsp_valid, aux_rsp_valid, busy}); else pass_cnt++;
        core_valid = 1; core_addr = 32'h304;
        #1;
        chk_cnt++; if (core_ready !== 1'b1) $display("FAIL rstmid_next_ready: got %b want 1", core_ready); else pass_cnt++;
        tick();
        core_valid = 0; l1d_gnt = 1;
        tick();
        l1d_gnt = 0; l1d_rvalid = 1; l1d_rdata = 32'h77;
        tick();
        l1d_rvalid = 0;
        chk_cnt++; if ({core_rsp_valid, core_rsp_rdata} !== {1'b1, 32'h77}) $display("FAIL rstmid_next_rsp: got v=%b d=%h want 1 77", core_rsp_valid, core_rsp_rdata); else pass_cnt++;
        $display("txn reset mid-op recovered, read addr=00000304 rdata=%h", core_rsp_rdata);
    endtask

    task automatic test_stray_rvalid();
        tick();
        l1d_rvalid = 1; l1d_rdata = 32'h99;
        tick();
        l1d_rvalid = 0;
        chk_cnt++; if ({busy, l1d_req, core_rsp_valid, aux_rsp_valid} !== 4'b0000) $display("FAIL stray_idle: got %b want 0000", {busy, l1d_req, core_rsp_valid, aux_rsp_valid}); else pass_cnt++;
        core_valid = 1; core_we = 0; core_addr = 32'h400;
        tick();
        core_valid = 0; l1d_rvalid = 1; l1d_rdata = 32'h98;
        tick();
        l1d_rvalid = 0;
        chk_cnt++; if ({busy, l1d_req, core_rsp_valid, aux_rsp_valid} !== 4'b1100) $display("FAIL stray_req: got %b want 1100", {busy, l1d_req, core_rsp_valid, aux_rsp_valid}); else pass_cnt++;
        l1d_gnt = 1;
        tick();
        l1d_gnt = 0; l1d_rvalid = 1; l1d_rdata = 32'h4242;
        tick();
        l1d_rvalid = 0;
        chk_cnt++; if ({core_rsp_valid, core_rsp_rdata} !== {1'b1, 32'h4242}) $display("FAIL stray_after_rsp: got v=%b d=%h want 1 4242", core_rsp_valid, core_rsp_rdata); else pass_cnt++;
        $display("txn stray rvalid ignored, read addr=00000400 rdata=%h", core_rsp_rdata);
    endtask

    // Transaction-level model: at most one outstanding access; the cache side
    // is a random-latency slave; responses go to the recorded owner.
    task automatic test_random();
        int          mcnt;
        bit          outstanding, granted, was_out, rv_now, aux_w, core_taken, aux_taken;
        int          rv_delay;
        bit          cur_owner, cur_we;
        logic [31:0] cur_addr, cur_wdata;
        logic [3:0]  cur_be;
        bit          exp_cv, exp_av;
        logic [31:0] held_cd, held_ad;
        int          n_txn;
        rst = 1; idle_inputs(); tick(); rst = 0;
        mcnt = 0; outstanding = 0; granted = 0; rv_delay = 0;
        cur_owner = 0; cur_we = 0; cur_addr = '0; cur_wdata = '0; cur_be = '0;
        exp_cv = 0; exp_av = 0; held_cd = '0; held_ad = '0;
        core_taken = 0; aux_taken = 0; n_txn = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            chk_cnt++; if ({core_rsp_valid, aux_rsp_valid} !== {exp_cv, exp_av}) $display("FAIL rnd_rsp_valid c%0d: got %b want %b", cyc, {core_rsp_valid, aux_rsp_valid}, {exp_cv, exp_av}); else pass_cnt++;
            chk_cnt++; if ({core_rsp_rdata, aux_rsp_rdata} !== {held_cd, held_ad}) $display("FAIL rnd_rsp_rdata c%0d: got %h %h want %h %h", cyc, core_rsp_rdata, aux_rsp_rdata, held_cd, held_ad); else pass_cnt++;
            chk_cnt++; if ({busy, l1d_req} !== {outstanding, outstanding && !granted}) $display("FAIL rnd_busy_req c%0d: got %b want %b", cyc, {busy, l1d_req}, {outstanding, outstanding && !granted}); else pass_cnt++;
            if (outstanding && !granted) begin
                chk_cnt++; if ({l1d_we, l1d_addr, l1d_wdata, l1d_be} !== {cur_we, cur_addr & 32'hFFFF_FFFC, cur_wdata, cur_be})
                    $display("FAIL rnd_fields c%0d: got we=%b a=%h d=%h be=%h want %b %h %h %h", cyc, l1d_we, l1d_addr, l1d_wdata, l1d_be, cur_we, cur_addr & 32'hFFFF_FFFC, cur_wdata, cur_be); else pass_cnt++;
            end
            if (!core_valid || core_taken) begin
                core_valid = ($urandom_range(0, 2) != 0);
                core_we = 1'($urandom); core_addr = $urandom; core_wdata = $urandom; core_be = 4'($urandom);
            end
            if (!aux_valid || aux_taken) begin
                aux_valid = ($urandom_range(0, 2) == 0);
                aux_we = 1'($urandom); aux_addr = $urandom; aux_wdata = $urandom; aux_be = 4'($urandom);
            end
            l1d_gnt    = (outstanding && !granted) ? 1'($urandom) : 1'b0;
            rv_now     = outstanding && granted && (rv_delay == 0);
            l1d_rvalid = rv_now ? 1'b1 : (!(outstanding && granted) && ($urandom_range(0, 7) == 0));
            l1d_rdata  = $urandom;
            #1;
            was_out = outstanding;
            aux_w   = aux_valid && (!core_valid || mcnt == MAXW);
            chk_cnt++; if ({core_ready, aux_ready} !== ((was_out || !(core_valid || aux_valid)) ? 2'b00 : (aux_w ? 2'b01 : 2'b10)))
                $display("FAIL rnd_ready c%0d: got %b want %b", cyc, {core_ready, aux_ready}, (was_out || !(core_valid || aux_valid)) ? 2'b00 : (aux_w ? 2'b01 : 2'b10)); else pass_cnt++;
            exp_cv = 0; exp_av = 0; core_taken = 0; aux_taken = 0;
            if (rv_now) begin
                if (cur_owner) begin exp_av = 1; held_ad = cur_we ? 32'h0 : l1d_rdata; end
                else begin exp_cv = 1; held_cd = cur_we ? 32'h0 : l1d_rdata; end
                outstanding = 0; granted = 0; n_txn++;
                $display("txn rnd #%0d %s %s addr=%h data=%h", n_txn, cur_owner ? "aux" : "core", cur_we ? "wr" : "rd", cur_addr, cur_we ? cur_wdata : l1d_rdata);
            end else if (outstanding && granted) begin
                rv_delay--;
            end
            if (outstanding && !granted && l1d_gnt) begin
                granted = 1; rv_delay = $urandom_range(0, 2);
            end
            if (!was_out && (core_valid || aux_valid)) begin
                outstanding = 1; granted = 0; cur_owner = aux_w;
                cur_we    = aux_w ? aux_we    : core_we;
                cur_addr  = aux_w ? aux_addr  : core_addr;
                cur_wdata = aux_w ? aux_wdata : core_wdata;
                cur_be    = aux_w ? aux_be    : core_be;
                if (aux_w) begin mcnt = 0; aux_taken = 1; end
                else begin
                    core_taken = 1;
                    if (aux_valid && mcnt < MAXW) mcnt++;
                end
            end
        end
        chk_cnt++; if (n_txn < 100) $display("FAIL rnd_progress: got %0d transactions want >= 100", n_txn); else pass_cnt++;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_aux_write_stall();
        test_starvation();
        test_back_to_back();
        test_reset_mid_op();
        test_stray_rvalid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed so far", pass_cnt, chk_cnt);
        $fatal(1, "timeout");
    end

endmodule
